// File: rtl/fpseq_pkg.sv
// Shared types and wrapper register map for the FP multiplier job sequencer.
// States, bus addresses, status bit positions and the start command word.
package fpseq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_A,
    WR_B,
    START,
    POLL,
    RD_P,
    CLR,
    RESP
  } state_e;

  localparam logic [1:0] ADDR_OPA  = 2'b00;
  localparam logic [1:0] ADDR_OPB  = 2'b01;
  localparam logic [1:0] ADDR_RES  = 2'b10;
  localparam logic [1:0] ADDR_CTRL = 2'b11;

  localparam int DONE_BIT  = 0;
  localparam int FLAG_LSB  = 8;
  localparam int FLAG_MSB  = 13;
  localparam int START_BIT = 16;

  localparam logic [31:0] START_WORD = 32'h0001_0000;

endpackage

// File: rtl/fpseq_arbiter.sv
// Two-way requester arbiter; FPSEQ_ROUND_ROBIN_EN selects round-robin,
// otherwise requester 0 has fixed priority.
module fpseq_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_valid_i,
  input  logic       adv_i,
  output logic [1:0] gnt_o
);

`ifdef FPSEQ_ROUND_ROBIN_EN
  logic ptr_q;

  always_comb begin
    gnt_o = 2'b00;
    if (req_valid_i == 2'b11)
      gnt_o = ptr_q ? 2'b10 : 2'b01;
    else
      gnt_o = req_valid_i;
  end

  // Pointer moves past whichever requester was just served.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr_q <= 1'b0;
    else if (adv_i && (|gnt_o))
      ptr_q <= gnt_o[0];
  end
`else
  logic unused_clk_rst;

  assign unused_clk_rst = clk ^ rst ^ adv_i;

  always_comb begin
    gnt_o = 2'b00;
    if (req_valid_i[0])
      gnt_o = 2'b01;
    else if (req_valid_i[1])
      gnt_o = 2'b10;
  end
`endif

endmodule

// File: rtl/fpmul_job_sequencer.sv
// Arbitrates two requesters onto one memory-mapped FP multiplier wrapper.
// Build option: FPSEQ_ROUND_ROBIN_EN enables round-robin arbitration.
module fpmul_job_sequencer
  import fpseq_pkg::*;
#(
  parameter int POLL_TIMEOUT = 1024,
  parameter int TO_W         = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_opa,
  input  logic [31:0] req0_opb,
  input  logic [31:0] req1_opa,
  input  logic [31:0] req1_opb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_prod,
  output logic [5:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy,
  output logic [1:0]  fp_a,
  output logic        fp_we,
  output logic [31:0] fp_wdata,
  input  logic [31:0] fp_rdata
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(POLL_TIMEOUT - 1);

  state_e          state_q;
  logic [TO_W-1:0] cnt_q;
  logic [31:0]     opb_q;
  logic [1:0]      gnt;
  logic            in_idle;

  assign in_idle   = (state_q == IDLE);
  assign req_ready = in_idle ? gnt : 2'b00;

  fpseq_arbiter u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .adv_i       (in_idle),
    .gnt_o       (gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opb_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_prod  <= '0;
      rsp_flags <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      fp_a      <= ADDR_OPA;
      fp_we     <= 1'b0;
      fp_wdata  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|gnt) begin
            rsp_id   <= gnt[1];
            rsp_err  <= 1'b0;
            opb_q    <= gnt[1] ? req1_opb : req0_opb;
            busy     <= 1'b1;
            fp_a     <= ADDR_OPA;
            fp_we    <= 1'b1;
            fp_wdata <= gnt[1] ? req1_opa : req0_opa;
            state_q  <= WR_A;
          end
        end
        WR_A: begin
          fp_a     <= ADDR_OPB;
          fp_wdata <= opb_q;
          state_q  <= WR_B;
        end
        WR_B: begin
          fp_a     <= ADDR_CTRL;
          fp_wdata <= START_WORD;
          state_q  <= START;
        end
        START: begin
          fp_we    <= 1'b0;
          fp_wdata <= '0;
          cnt_q    <= '0;
          state_q  <= POLL;
        end
        POLL: begin
          cnt_q <= cnt_q + 1'b1;
          if (fp_rdata[DONE_BIT]) begin
            rsp_flags <= fp_rdata[FLAG_MSB:FLAG_LSB];
            fp_a      <= ADDR_RES;
            state_q   <= RD_P;
          end else if (cnt_q == TO_LAST) begin
            rsp_err   <= 1'b1;
            rsp_flags <= '0;
            rsp_prod  <= '0;
            fp_we     <= 1'b1;
            fp_wdata  <= '0;
            state_q   <= CLR;
          end
        end
        RD_P: begin
          rsp_prod <= fp_rdata;
          fp_a     <= ADDR_CTRL;
          fp_we    <= 1'b1;
          fp_wdata <= '0;
          state_q  <= CLR;
        end
        CLR: begin
          fp_we     <= 1'b0;
          rsp_valid <= 1'b1;
          state_q   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpmul_job_sequencer.sv
// Directed bench for fpmul_job_sequencer with a behavioural wrapper model
// and a response scoreboard.
module tb_fpmul_job_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req0_opa, req0_opb, req1_opa, req1_opb;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err, busy, fp_we;
  logic [31:0] rsp_prod, fp_wdata, fp_rdata;
  logic [5:0]  rsp_flags;
  logic [1:0]  fp_a;

  always #5 clk = ~clk;

  fpmul_job_sequencer #(.POLL_TIMEOUT(16), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_opa(req0_opa), .req0_opb(req0_opb),
    .req1_opa(req1_opa), .req1_opb(req1_opb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_prod(rsp_prod),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .busy(busy), .fp_a(fp_a), .fp_we(fp_we),
    .fp_wdata(fp_wdata), .fp_rdata(fp_rdata)
  );

  int tests = 0;
  int fails = 0;
  int grants = 0;
  int rsp_seen = 0;
  int polls = 0;
  int rds = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] prod;
    logic [5:0]  flags;
    logic        err;
  } exp_t;

  exp_t        sbq[$];
  logic [33:0] trace[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Simple single-precision multiply for normal/zero operands.
  function automatic logic [37:0] fmul(input logic [31:0] a,
                                       input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] m;
    logic [22:0] f;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0)
      return {6'b000001, s, 31'b0};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    m = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    if (m[47]) begin
      f = m[46:24];
      e++;
    end else begin
      f = m[45:23];
    end
    if (e >= 255) return {6'b100100, s, 8'hFF, 23'b0};
    if (e <= 0) return {6'b010001, s, 31'b0};
    return {6'b000000, s, e[7:0], f};
  endfunction

  logic [31:0] w_a = '0, w_b = '0, w_p = '0;
  logic [5:0]  w_f = '0;
  logic        w_start = 1'b0, w_done = 1'b0;
  int          w_cnt = 0;
  bit          stub = 1'b0;
  bit          in_job = 1'b0;

  always_comb begin
    fp_rdata = '0;
    case (fp_a)
      2'b00: fp_rdata = w_a;
      2'b01: fp_rdata = w_b;
      2'b10: fp_rdata = w_p;
      default: fp_rdata = {15'b0, w_start, 2'b0, w_f, 7'b0, w_done};
    endcase
  end

  always @(posedge clk) begin
    if (in_job && !fp_we && fp_a == 2'b11) polls++;
    if (in_job && !fp_we && fp_a == 2'b10) rds++;
    if (fp_we) begin
      trace.push_back({fp_a, fp_wdata});
      case (fp_a)
        2'b00: w_a <= fp_wdata;
        2'b01: w_b <= fp_wdata;
        2'b11: begin
          w_start <= fp_wdata[16];
          in_job  <= fp_wdata[16];
          if (fp_wdata[16]) begin
            w_done <= 1'b0;
            w_cnt  <= 3;
          end
        end
        default: ;
      endcase
    end else if (w_cnt > 0) begin
      w_cnt <= w_cnt - 1;
      if (w_cnt == 1 && !stub) begin
        {w_f, w_p} <= fmul(w_a, w_b);
        w_done     <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst && (|req_ready)) grants++;
    if (rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_id", 64'(rsp_id), 64'(e.id));
        chk("rsp_prod", 64'(rsp_prod), 64'(e.prod));
        chk("rsp_flags", 64'(rsp_flags), 64'(e.flags));
        chk("rsp_err", 64'(rsp_err), 64'(e.err));
      end
      rsp_seen++;
    end
  end

  task automatic wait_grant(input int target);
    int n = 0;
    while (grants < target && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("grant_timeout", 64'(grants >= target), 64'd1);
    #1;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_seen < target && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("rsp_timeout", 64'(rsp_seen >= target), 64'd1);
    #1;
  endtask

  task automatic job(input bit id, input logic [31:0] a,
                     input logic [31:0] b);
    if (id) begin
      req1_opa = a;
      req1_opb = b;
    end else begin
      req0_opa = a;
      req0_opb = b;
    end
    req_valid[id] = 1'b1;
    wait_grant(grants + 1);
    req_valid[id] = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    chk({tag, "_fp_we"}, 64'(fp_we), 64'd0);
    chk({tag, "_fp_a"}, 64'(fp_a), 64'd0);
    chk({tag, "_fp_wdata"}, 64'(fp_wdata), 64'd0);
    chk({tag, "_rsp_prod"}, 64'(rsp_prod), 64'd0);
    chk({tag, "_rsp_flags"}, 64'(rsp_flags), 64'd0);
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
    chk({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req0_opa = '0; req0_opb = '0;
    req1_opa = '0; req1_opb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk); #1;

    // 2.0 * 3.0 on requester 0, with bus order check
    trace.delete(); polls = 0; rds = 0;
    sbq.push_back('{1'b0, 32'h40C0_0000, 6'd0, 1'b0});
    job(1'b0, 32'h4000_0000, 32'h4040_0000);
    wait_rsp(1);
    chk("trace_len", 64'(trace.size()), 64'd4);
    chk("bus_opa", 64'(trace[0]), {30'd0, 2'b00, 32'h4000_0000});
    chk("bus_opb", 64'(trace[1]), {30'd0, 2'b01, 32'h4040_0000});
    chk("bus_start", 64'(trace[2]), {30'd0, 2'b11, 32'h0001_0000});
    chk("bus_clr", 64'(trace[3]), {30'd0, 2'b11, 32'h0000_0000});
    chk("poll_cycles", 64'(polls), 64'd4);
    chk("prod_reads", 64'(rds), 64'd1);

    // Overflow on requester 1
    sbq.push_back('{1'b1, 32'h7F80_0000, 6'b100100, 1'b0});
    job(1'b1, 32'h7F00_0000, 32'h7F00_0000);
    wait_rsp(2);

    // Wrapper never finishes: timeout after 16 polls
    stub = 1'b1; polls = 0; trace.delete();
    sbq.push_back('{1'b1, 32'h0, 6'd0, 1'b1});
    job(1'b1, 32'h3F80_0000, 32'h3F80_0000);
    wait_rsp(3);
    chk("timeout_polls", 64'(polls), 64'd16);
    chk("timeout_clr", 64'(trace[trace.size()-1]), {30'd0, 2'b11, 32'h0});
    stub = 1'b0;

    // Both requesters held valid for four jobs
    req0_opa = 32'h4000_0000; req0_opb = 32'h4040_0000;
    req1_opa = 32'h3F80_0000; req1_opb = 32'h4000_0000;
`ifdef FPSEQ_ROUND_ROBIN_EN
    for (int i = 0; i < 4; i++)
      if (i % 2 == 0) sbq.push_back('{1'b0, 32'h40C0_0000, 6'd0, 1'b0});
      else sbq.push_back('{1'b1, 32'h4000_0000, 6'd0, 1'b0});
`else
    for (int i = 0; i < 4; i++)
      sbq.push_back('{1'b0, 32'h40C0_0000, 6'd0, 1'b0});
`endif
    req_valid = 2'b11;
    wait_rsp(7);
    req_valid = 2'b00;

    // Response backpressure with requester 1 waiting
    rsp_ready = 1'b0;
    sbq.push_back('{1'b0, 32'h40C0_0000, 6'd0, 1'b0});
    sbq.push_back('{1'b1, 32'h4000_0000, 6'd0, 1'b0});
    req_valid = 2'b11;
    wait_grant(grants + 1);
    req_valid = 2'b10;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid && n < 50);
    chk("bp_rsp_valid_rise", 64'(rsp_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_prod", 64'(rsp_prod), 64'h40C0_0000);
      chk("bp_id", 64'(rsp_id), 64'd0);
      chk("bp_no_grant", 64'(req_ready), 64'd0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    wait_rsp(8);
    @(negedge clk);
    chk("grant_after_hs", 64'(req_ready), 64'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    wait_rsp(9);

    // Reset while polling drops the job
    stub = 1'b1;
    req0_opa = 32'h4000_0000; req0_opb = 32'h4040_0000;
    req_valid = 2'b01;
    wait_grant(grants + 1);
    req_valid = 2'b00;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(busy && fp_a == 2'b11 && !fp_we) && n < 20);
    chk("reached_poll", 64'(busy && fp_a == 2'b11 && !fp_we), 64'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outs("midrst");
    @(posedge clk); #1 rst = 1'b1;
    stub = 1'b0;
    repeat (30) @(posedge clk);
    chk("no_rsp_after_rst", 64'(rsp_seen), 64'd9);
    #1;
    sbq.push_back('{1'b1, 32'h4000_0000, 6'd0, 1'b0});
    job(1'b1, 32'h3F80_0000, 32'h4000_0000);
    wait_rsp(10);
    chk("sb_empty", 64'(sbq.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
